pipeline_ctrl: RTL

Parametrised pipeline load/stall/flush controller for the RV32I core. It generates per-stage load enables and per-stage valid bits for an N-stage in-order pipeline from three inputs: instruction-memory handshakes, data-memory handshakes, and hazard/flush requests from the datapath. It replaces the fixed four-enable stage sequencer and adds:
- partial stalls with bubble insertion;
- deferred flush;
- a saturating stall counter and a memory-wait watchdog.

---
 rtl/rv32i_types.sv | 21 ++
 rtl/sat_counter.sv | 41 ++++
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: pipeline stage indices and the controller mode.
// Contents:
//   STAGE_IF..STAGE_WB  stage index localparams for the default 5-stage pipe
//   ctrl_mode_t         per-cycle pipeline controller mode
package rv32i_types;

  localparam int unsigned STAGE_IF  = 0;
  localparam int unsigned STAGE_ID  = 1;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 3;
  localparam int unsigned STAGE_WB  = 4;

  typedef enum logic [2:0] {
    RUN,
    FREEZE,
    FLUSH,
    HAZARD,
    IFETCH
  } ctrl_mode_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   inc       count up by one (ignored once saturated)
//   clr       clear to zero (wins over inc)
//   count     current count
//   sat       count is all ones
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q, count_d;

  assign sat   = &count_q;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline load/stall/flush controller for the RV32I core.
// Produces per-stage load enables (combinational) and per-stage valid bits
// (registered) from memory handshakes and hazard/flush requests.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   inst_read, inst_resp  instruction-memory request / response
//   data_read, data_write data-memory requests from MEM_STAGE
//   data_resp             data-memory response
//   hazard_stall          load-use hazard in ID
//   flush                 redirect from FLUSH_STAGE
//   load                  per-stage pipeline register load enable
//   valid                 per-stage live-instruction flag
//   stall_count           saturating count of stalled cycles
//   mem_timeout           sticky memory-wait watchdog error
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned NUM_STAGES  = STAGE_WB + 1,
  parameter int unsigned MEM_STAGE   = STAGE_MEM,
  parameter int unsigned FLUSH_STAGE = STAGE_EX,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_read,
  input  logic                  inst_resp,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic                  data_resp,
  input  logic                  hazard_stall,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] load,
  output logic [NUM_STAGES-1:0] valid,
  output logic [31:0]           stall_count,
  output logic                  mem_timeout
);

  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);
  // Stages 1..FLUSH_STAGE are squashed on a flush.
  localparam logic [NUM_STAGES-1:0] FlushMask =
      NUM_STAGES'((32'd1 << (FLUSH_STAGE + 1)) - 32'd2);

  logic [NUM_STAGES-1:0] valid_q, valid_d, shifted;
  logic                  flush_pending_q, flush_pending_d;
  logic                  mem_timeout_q, mem_timeout_d;
  logic                  imem_stall, dmem_stall, mem_stall;
  logic                  stall_cycle, stall_sat;
  logic [WdWidth-1:0]    wd_count;
  logic                  wd_sat;
  ctrl_mode_t            mode;

  assign imem_stall = inst_read & ~inst_resp;
  assign dmem_stall = valid_q[MEM_STAGE] & (data_read | data_write) & ~data_resp;
  assign mem_stall  = imem_stall | dmem_stall;

  always_comb begin
    if (dmem_stall) begin
      mode = FREEZE;
    end else if (flush || flush_pending_q) begin
      mode = FLUSH;
    end else if (hazard_stall) begin
      mode = HAZARD;
    end else if (imem_stall) begin
      mode = IFETCH;
    end else begin
      mode = RUN;
    end
  end

  always_comb begin
    load = '1;
    case (mode)
      FREEZE: load = '0;
      HAZARD: begin
        load[STAGE_IF] = 1'b0;
        load[STAGE_ID] = 1'b0;
      end
      IFETCH: load[STAGE_IF] = 1'b0;
      default: ;
    endcase
    if (rst) begin
      load = '0;
    end
  end

  // IF always holds a live instruction once out of reset.
  assign shifted = {valid_q[NUM_STAGES-2:0], 1'b1};

  always_comb begin
    valid_d = shifted;
    case (mode)
      FREEZE: valid_d = valid_q;
      FLUSH:  valid_d = shifted & ~FlushMask;
      HAZARD: begin
        valid_d[STAGE_ID] = valid_q[STAGE_ID];
        valid_d[STAGE_EX] = 1'b0;
      end
      IFETCH: valid_d[STAGE_ID] = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    flush_pending_d = flush_pending_q;
    if (mode == FREEZE) begin
      flush_pending_d = flush_pending_q | flush;
    end else if (mode == FLUSH) begin
      flush_pending_d = 1'b0;
    end
  end

  assign stall_cycle = (mode == FREEZE) || (mode == HAZARD) || (mode == IFETCH);

  // wd_sat covers a TIMEOUT equal to the counter's maximum value.
  assign mem_timeout_d = mem_timeout_q |
                         (mem_stall & ((wd_count == WdWidth'(TIMEOUT)) | wd_sat));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      mem_timeout_q   <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      mem_timeout_q   <= mem_timeout_d;
    end
  end

  sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_cycle & ~stall_sat),
    .clr   (1'b0),
    .count (stall_count),
    .sat   (stall_sat)
  );

  sat_counter #(
    .WIDTH (WdWidth)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall),
    .clr   (~mem_stall),
    .count (wd_count),
    .sat   (wd_sat)
  );

  assign valid       = valid_q;
  assign mem_timeout = mem_timeout_q;

endmodule
